// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole game controller: state encoding,
// grid geometry and small arithmetic helpers.
package mole_pkg;

    localparam int HOLE_W    = 4;
    localparam int NUM_HOLES = 9;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN_ENC = 2'd1;
    localparam logic [1:0] ST_PLAY_ENC      = 2'd2;
    localparam logic [1:0] ST_OVER_ENC      = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ST_IDLE_ENC,
        ST_COUNTDOWN = ST_COUNTDOWN_ENC,
        ST_PLAY      = ST_PLAY_ENC,
        ST_OVER      = ST_OVER_ENC
    } state_t;

    // Adds b to a and clamps the result at max_v.
    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b,
                                           input logic [9:0] max_v);
        logic [10:0] sum_v;
        sum_v = {1'b0, a} + {1'b0, b};
        if (sum_v > {1'b0, max_v}) begin
            return max_v;
        end else begin
            return sum_v[9:0];
        end
    endfunction

    function automatic logic [HOLE_W-1:0] mod9(input logic [9:0] v);
        logic [9:0] rem_v;
        rem_v = v % 10'd9;
        return rem_v[HOLE_W-1:0];
    endfunction

    function automatic logic [HOLE_W-1:0] popcount9(input logic [NUM_HOLES-1:0] v);
        logic [HOLE_W-1:0] n_v;
        n_v = {HOLE_W{1'b0}};
        for (int i = 0; i < NUM_HOLES; i++) begin
            n_v = n_v + {{(HOLE_W-1){1'b0}}, v[i]};
        end
        return n_v;
    endfunction

    function automatic logic [HOLE_W-1:0] next_hole(input logic [HOLE_W-1:0] h);
        if (h >= 4'(NUM_HOLES - 1)) begin
            return 4'd0;
        end else begin
            return h + 4'd1;
        end
    endfunction

endpackage

// File: rtl/mole_hole_timer.sv
// Per-hole show timer: a loaded mole stays visible for exactly load_val cycles
// unless cleared; expire_pulse flags the last visible cycle.
module mole_hole_timer
    import mole_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clear,
    output logic             active,
    output logic             expire_pulse
);

    logic [CNT_W-1:0] cnt_r;
    logic             active_r;

    // Countdown register; clear has priority so a hit or round end always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else if (clear) begin
            cnt_r    <= {CNT_W{1'b0}};
            active_r <= 1'b0;
        end else if (load) begin
            cnt_r    <= load_val;
            active_r <= 1'b1;
        end else if (active_r) begin
            if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                cnt_r    <= {CNT_W{1'b0}};
                active_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign active       = active_r;
    assign expire_pulse = active_r && (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round controller: FSM, game clock, mole spawning, hits and misses.
// Optional MOLE_MISS_PENALTY_EN: a click on an empty hole during play counts as a miss.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int MAX_ACTIVE    = 3,
    parameter int TICKS_PER_SEC = 40_000_000,
    parameter int COUNTDOWN_S   = 3,
    parameter int GAME_S        = 60,
    parameter int SPAWN_PERIOD  = 40_000_000,
    parameter int SHOW_INIT     = 60_000_000,
    parameter int SHOW_MIN      = 24_000_000,
    parameter int SHOW_DEC      = 1_200_000,
    parameter int MAX_MISSES    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9:0]           random_number,
    input  logic                 hit_valid,
    input  logic [HOLE_W-1:0]    hit_hole,
    output logic [NUM_HOLES-1:0] active_mask,
    output logic                 spawn_pulse,
    output logic [HOLE_W-1:0]    spawn_hole,
    output logic [9:0]           score,
    output logic [3:0]           missed,
    output logic [6:0]           time_left,
    output logic [1:0]           game_state
);

    state_t              state_r, state_nxt_s;
    logic [31:0]         sec_cnt_r, spawn_cnt_r, show_time_r, show_nxt_s;
    logic [9:0]          score_r, score_nxt_s, miss_sum_s;
    logic [3:0]          missed_r, missed_nxt_s;
    logic [6:0]          time_left_r;
    logic                spawn_pulse_r;
    logic [HOLE_W-1:0]   spawn_hole_r;

    logic [NUM_HOLES-1:0] mask_s, expire_vec_s, exp_vec_s, hit_vec_s, load_vec_s, clear_vec_s;
    logic                 sec_tick_s, spawn_wrap_s, hit_ok_s, hit_any_s, pen_s;
    logic                 room_s, found_s, spawn_go_s, clear_all_s;
    logic [HOLE_W-1:0]    exp_cnt_s, probe_s, spawn_idx_s;

    assign sec_tick_s   = (sec_cnt_r == 32'(TICKS_PER_SEC - 1));
    assign spawn_wrap_s = (state_r == ST_PLAY) && (spawn_cnt_r == 32'(SPAWN_PERIOD - 1));
    assign hit_ok_s     = hit_valid && (hit_hole < 4'(NUM_HOLES)) && (state_r == ST_PLAY);
    assign room_s       = (popcount9(mask_s) < 4'(MAX_ACTIVE));
    assign clear_all_s  = (state_nxt_s != ST_PLAY);
    assign spawn_go_s   = spawn_wrap_s && room_s && found_s && !clear_all_s;

    // Per-hole hit decode; a hit masks that hole's expiry so it is never also a miss.
    always_comb begin
        hit_vec_s = {NUM_HOLES{1'b0}};
        for (int i = 0; i < NUM_HOLES; i++) begin
            hit_vec_s[i] = hit_ok_s && (hit_hole == 4'(i)) && mask_s[i];
        end
        hit_any_s = |hit_vec_s;
        exp_vec_s = expire_vec_s & ~hit_vec_s;
        exp_cnt_s = popcount9(exp_vec_s);
`ifdef MOLE_MISS_PENALTY_EN
        pen_s = hit_ok_s && !hit_any_s;
`else
        pen_s = 1'b0;
`endif
    end

    // Score, miss and show-time updates for the current cycle.
    always_comb begin
        miss_sum_s   = sat_add({6'd0, missed_r}, {6'd0, exp_cnt_s} + {9'd0, pen_s}, 10'd15);
        missed_nxt_s = miss_sum_s[3:0];
        if (hit_any_s) begin
            score_nxt_s = sat_add(score_r, 10'd1, 10'd1023);
        end else begin
            score_nxt_s = score_r;
        end
        if (hit_any_s && (show_time_r >= 32'(SHOW_MIN + SHOW_DEC))) begin
            show_nxt_s = show_time_r - 32'(SHOW_DEC);
        end else begin
            show_nxt_s = show_time_r;
        end
    end

    // Linear probe from random%9 for the first free hole, using last cycle's mask.
    always_comb begin
        probe_s     = mod9(random_number);
        found_s     = 1'b0;
        spawn_idx_s = 4'd0;
        for (int k = 0; k < NUM_HOLES; k++) begin
            if (!found_s && !mask_s[probe_s]) begin
                found_s     = 1'b1;
                spawn_idx_s = probe_s;
            end else begin
                found_s = found_s;
            end
            probe_s = next_hole(probe_s);
        end
        for (int i = 0; i < NUM_HOLES; i++) begin
            load_vec_s[i]  = spawn_go_s && (spawn_idx_s == 4'(i));
            clear_vec_s[i] = hit_vec_s[i] || clear_all_s;
        end
    end

    // Round FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_nxt_s = ST_COUNTDOWN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_COUNTDOWN: begin
                if (sec_tick_s && (time_left_r <= 7'd1)) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_COUNTDOWN;
                end
            end
            ST_PLAY: begin
                if ((missed_nxt_s >= 4'(MAX_MISSES)) || (sec_tick_s && (time_left_r <= 7'd1))) begin
                    state_nxt_s = ST_OVER;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Second prescaler and HUD countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_r   <= 32'd0;
            time_left_r <= 7'(GAME_S);
        end else begin
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    sec_cnt_r <= 32'd0;
                    if (start) begin
                        time_left_r <= 7'(COUNTDOWN_S);
                    end
                end
                ST_COUNTDOWN: begin
                    if (sec_tick_s) begin
                        sec_cnt_r   <= 32'd0;
                        time_left_r <= (time_left_r <= 7'd1) ? 7'(GAME_S) : time_left_r - 7'd1;
                    end else begin
                        sec_cnt_r <= sec_cnt_r + 32'd1;
                    end
                end
                ST_PLAY: begin
                    if (sec_tick_s) begin
                        sec_cnt_r   <= 32'd0;
                        time_left_r <= time_left_r - 7'd1;
                    end else begin
                        sec_cnt_r <= sec_cnt_r + 32'd1;
                    end
                end
                default: sec_cnt_r <= 32'd0;
            endcase
        end
    end

    // Score, misses and difficulty ramp; a new round restarts all three.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_r     <= 10'd0;
            missed_r    <= 4'd0;
            show_time_r <= 32'(SHOW_INIT);
        end else if (((state_r == ST_IDLE) || (state_r == ST_OVER)) && start) begin
            score_r     <= 10'd0;
            missed_r    <= 4'd0;
            show_time_r <= 32'(SHOW_INIT);
        end else if (state_r == ST_PLAY) begin
            score_r     <= score_nxt_s;
            missed_r    <= missed_nxt_s;
            show_time_r <= show_nxt_s;
        end
    end

    // Spawn period counter and registered spawn report.
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_cnt_r   <= 32'd0;
            spawn_pulse_r <= 1'b0;
            spawn_hole_r  <= 4'd0;
        end else begin
            if ((state_r != ST_PLAY) || spawn_wrap_s) begin
                spawn_cnt_r <= 32'd0;
            end else begin
                spawn_cnt_r <= spawn_cnt_r + 32'd1;
            end
            spawn_pulse_r <= spawn_go_s;
            if (spawn_go_s) begin
                spawn_hole_r <= spawn_idx_s;
            end
        end
    end

    for (genvar g = 0; g < NUM_HOLES; g++) begin : g_hole
        mole_hole_timer #(.CNT_W(32)) u_timer (
            .clk          (clk),
            .rst          (rst),
            .load         (load_vec_s[g]),
            .load_val     (show_time_r),
            .clear        (clear_vec_s[g]),
            .active       (mask_s[g]),
            .expire_pulse (expire_vec_s[g])
        );
    end

    assign active_mask = mask_s;
    assign spawn_pulse = spawn_pulse_r;
    assign spawn_hole  = spawn_hole_r;
    assign score       = score_r;
    assign missed      = missed_r;
    assign time_left   = time_left_r;
    assign game_state  = state_r;

endmodule
